mul32_sched: RTL
================

Name: mul32_sched

Overview:
- Round-robin scheduler that shares one mul32 sequential multiplier between NREQ independent requesters, e.g. the Wishbone register file and LA-driven test ports.
- Accepts operand pairs over valid/ready, sequences the mul32 start/done handshake, and returns the 64-bit product to the granted requester over valid/ready.
- Sits between the requesters and the single mul32 instance in the user project.

Parameters:
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 255, maximum cycles in WAIT before abort (used only with MUL_TIMEOUT_EN); counter width $clog2(TIMEOUT+1)

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept strobe
- req_mc  in  32*NREQ  multiplicand, requester i at [32i+31:32i]
- req_mp  in  32*NREQ  multiplier, same packing
- rsp_valid  out  NREQ  result valid, one-hot
- rsp_ready  in  NREQ  result accept
- rsp_p  out  64  product, shared bus
- rsp_err  out  1  result aborted by timeout
- grant_id  out  $clog2(NREQ)  index of current owner
- busy  out  1  high in any state other than IDLE
- mul_start  out  1  start pulse to mul32
- mul_mc  out  32  multiplicand to mul32
- mul_mp  out  32  multiplier to mul32
- mul_p  in  64  product from mul32
- mul_done  in  1  mul32 done level

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, all outputs 0, captured operands 0.
- FSM: IDLE -> START -> ARM -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, grant the first set bit scanning upward from rr_ptr with wrap.
  - Assert req_ready[g] combinationally in the same cycle; handshake = req_valid&req_ready.
  - Capture req_mc/req_mp of g into mul_mc/mul_mp; latch grant_id=g; go START.
  - If no req_valid is high: stay in IDLE, req_ready=0.
- START: mul_start=1 for exactly this cycle; go ARM.
- ARM: mul_done ignored for one cycle, masking a stale done from the previous operation; go WAIT.
  - mul32 contract: done deasserts within one cycle of a sampled start.
- WAIT: on mul_done=1, register rsp_p<=mul_p and rsp_err<=0; go RESP.
- RESP:
  - rsp_valid[g]=1 with rsp_p and rsp_err stable until rsp_ready[g]=1.
  - On handshake: rr_ptr<=(g+1) mod NREQ, rsp_valid<=0, go IDLE.
- mul_mc/mul_mp stay stable from START through RESP; they change only at the next grant.
- Minimum latency: accept at cycle 0, mul_start at cycle 1, rsp_valid at cycle 4 if mul_done is already high in cycle 3.
- At most one operation in flight; req_ready=0 for all requesters outside IDLE.
- Other requesters simply wait; the granted requester may re-assert req_valid during RESP but is not re-accepted until IDLE.
- req_valid dropped before acceptance: no effect; operands must be held while valid.
- All NREQ valid simultaneously: service order g, g+1, ... in strict rotation; no requester waits more than NREQ-1 operations.
- rsp_ready asserted for a non-granted index: ignored.
- Reset mid-operation: immediate return to IDLE, outputs cleared, no rsp_valid emitted; mul32 shares wb_rst_i.

Optional Feature:
- Macro: MUL_TIMEOUT_EN.
- Defined:
  - A WAIT-state cycle counter clears on WAIT entry.
  - If it reaches TIMEOUT with mul_done still 0: go RESP with rsp_p=0 and rsp_err=1.
  - A mul_done arriving on the same cycle as the limit wins, giving a normal result.
- Undefined: no counter; WAIT lasts until mul_done; rsp_err tied 0.
- The rsp_err port exists in both builds.

Test Plan:
- Reset, then requester 1 sends mc=0x0000_0003, mp=0x0000_0005; model done 2 cycles after start -> req_ready[1] same cycle; one mul_start pulse; rsp_valid=4'b0010; rsp_p=0x0F; rsp_err=0.
- All four requesters valid from rr_ptr=0 with mc=i+1, mp=0x10 -> grants in order 0,1,2,3; products 0x10,0x20,0x30,0x40; next burst starts at requester 0.
- Stale done: mul_done held high through START/ARM -> result captured no earlier than WAIT; rsp_p equals the new product 0xFFFF_FFFE_0000_0001 for mc=mp=0xFFFF_FFFF.
- Back-pressure: rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_p and grant_id stable; busy=1; no req_ready to other requesters.
- Assert wb_rst_i during WAIT -> busy=0 and rsp_valid=0 on the next edge; fresh request afterwards completes correctly with rr_ptr=0.
- MUL_TIMEOUT_EN, TIMEOUT=8, mul_done stuck 0 -> rsp_valid after 8 WAIT cycles; rsp_err=1; rsp_p=0.

Source files
------------

// File: rtl/mul32_sched.sv
// Round-robin scheduler sharing one mul32 sequential multiplier between NREQ requesters.
// Optional WAIT-state abort counter enabled by defining MUL_TIMEOUT_EN.
module mul32_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_mc,
  input  logic [32*NREQ-1:0]   req_mp,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [63:0]          rsp_p,
  output logic                 rsp_err,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                 busy,
  output logic                 mul_start,
  output logic [31:0]          mul_mc,
  output logic [31:0]          mul_mp,
  input  logic [63:0]          mul_p,
  input  logic                 mul_done
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [2:0] {S_IDLE, S_START, S_ARM, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic            found;
  logic [GW-1:0]   gnt;
  logic            timeout_hit;

`ifdef MUL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;

  // Limit is reached on the TIMEOUT-th WAIT cycle; a done on that same cycle still wins.
  assign timeout_hit = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT - 1));
  assign rsp_err     = err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // First valid requester scanning upward from rr_ptr with wrap.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    for (int unsigned i = 0; i < unsigned'(NREQ); i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= unsigned'(NREQ)) idx = idx - unsigned'(NREQ);
      if (!found && req_valid[GW'(idx)]) begin
        found = 1'b1;
        gnt   = GW'(idx);
      end
    end
  end

  assign req_ready = (state == S_IDLE && found) ? (NREQ'(1) << gnt) : '0;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_mc    <= '0;
      mul_mp    <= '0;
      rsp_valid <= '0;
      rsp_p     <= '0;
`ifdef MUL_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            mul_mc    <= req_mc[32*gnt +: 32];
            mul_mp    <= req_mp[32*gnt +: 32];
            grant_id  <= gnt;
            busy      <= 1'b1;
            mul_start <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          mul_start <= 1'b0;
          state     <= S_ARM;
        end
        S_ARM: begin
`ifdef MUL_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
`ifdef MUL_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
`endif
          if (mul_done) begin
            rsp_p     <= mul_p;
            rsp_valid <= NREQ'(1) << grant_id;
`ifdef MUL_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            state     <= S_RESP;
          end else if (timeout_hit) begin
            rsp_p     <= '0;
            rsp_valid <= NREQ'(1) << grant_id;
`ifdef MUL_TIMEOUT_EN
            err_q     <= 1'b1;
`endif
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid <= '0;
            rr_ptr    <= (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
